// File: rtl/downsample_mul_pkg.sv
// Shared widths, requester tag type and the saturation helper for the DownSample multiply arbiter.
// sat_p is only referenced when DOWNSAMPLE_MUL_SAT_EN is defined.
package downsample_mul_pkg;
  localparam int DS_NUM_REQ   = 4;
  localparam int DS_A_W       = 6;
  localparam int DS_B_W       = 10;
  localparam int DS_P_W       = 10;
  localparam int DS_NUM_STAGE = 2;
  localparam int DS_ID_W      = 2;
  localparam int DS_FULL_W    = DS_A_W + DS_B_W;

  typedef logic [DS_ID_W-1:0] id_t;

  localparam logic signed [DS_FULL_W-1:0] P_MAX = DS_FULL_W'((1 << (DS_P_W-1)) - 1);
  localparam logic signed [DS_FULL_W-1:0] P_MIN = DS_FULL_W'(-(1 << (DS_P_W-1)));

  function automatic logic [DS_P_W-1:0] sat_p(input logic signed [DS_FULL_W-1:0] full);
    logic [DS_P_W-1:0] res;
    if (full > P_MAX)      res = P_MAX[DS_P_W-1:0];
    else if (full < P_MIN) res = P_MIN[DS_P_W-1:0];
    else                   res = full[DS_P_W-1:0];
    return res;
  endfunction
endpackage

// File: rtl/downsample_mul_rr_arb.sv
// Round-robin grant over NUM_REQ requesters; pointer moves past the winner only on an accepted grant.
module downsample_mul_rr_arb
  import downsample_mul_pkg::*;
#(
  parameter int NUM_REQ  = DS_NUM_REQ,
  parameter int ID_WIDTH = DS_ID_W
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic [NUM_REQ-1:0]  i_req_valid,
  input  logic                i_adv,
  output logic [NUM_REQ-1:0]  o_grant,
  output logic [ID_WIDTH-1:0] o_idx,
  output logic                o_any
);
  logic [ID_WIDTH-1:0] r_ptr;
  logic [ID_WIDTH-1:0] w_idx;
  logic                w_any;
  int                  w_j;

  // Walk offsets high to low so the nearest valid requester past r_ptr wins.
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    w_j   = 0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      w_j = (int'(r_ptr) + k) % NUM_REQ;
      if (i_req_valid[w_j]) begin
        w_any = 1'b1;
        w_idx = ID_WIDTH'(w_j);
      end
    end
  end

  assign o_any   = w_any;
  assign o_idx   = w_idx;
  assign o_grant = w_any ? (NUM_REQ'(1) << w_idx) : '0;

  always_ff @(posedge ap_clk) begin
    if (ap_rst)
      r_ptr <= '0;
    else if (w_any && i_adv)
      r_ptr <= (int'(w_idx) == NUM_REQ-1) ? '0 : w_idx + ID_WIDTH'(1);
  end
endmodule

// File: rtl/downsample_mul_arbiter.sv
// One shared coefficient x pixel multiplier behind a round-robin arbiter, results tagged by requester.
// Define DOWNSAMPLE_MUL_SAT_EN to saturate the product instead of truncating it.
module downsample_mul_arbiter
  import downsample_mul_pkg::*;
#(
  parameter int NUM_REQ   = DS_NUM_REQ,
  parameter int A_WIDTH   = DS_A_W,
  parameter int B_WIDTH   = DS_B_W,
  parameter int P_WIDTH   = DS_P_W,
  parameter int NUM_STAGE = DS_NUM_STAGE,
  parameter int ID_WIDTH  = DS_ID_W
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_WIDTH-1:0]        rsp_id,
  output logic [P_WIDTH-1:0]         rsp_p
);
  localparam int FULL_W = A_WIDTH + B_WIDTH;

  logic [NUM_STAGE:1]               r_vld_pipe;
  logic [NUM_STAGE:1][ID_WIDTH-1:0] r_id;
  logic [NUM_STAGE:1][P_WIDTH-1:0]  r_p;

  logic                      w_adv;
  logic                      w_accept;
  logic                      w_any;
  logic [NUM_REQ-1:0]        w_grant;
  logic [ID_WIDTH-1:0]       w_idx;
  logic [A_WIDTH-1:0]        w_a;
  logic [B_WIDTH-1:0]        w_b;
  logic signed [A_WIDTH:0]   w_as;
  logic signed [FULL_W-1:0]  w_full;
  logic [P_WIDTH-1:0]        w_p1;

  // Whole pipeline freezes while the head result waits on downstream.
  assign w_adv     = !r_vld_pipe[NUM_STAGE] || rsp_ready;
  assign req_ready = (ap_rst || !w_adv) ? '0 : w_grant;
  assign w_accept  = w_any && w_adv && !ap_rst;

  downsample_mul_rr_arb #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .i_req_valid (req_valid),
    .i_adv       (w_adv),
    .o_grant     (w_grant),
    .o_idx       (w_idx),
    .o_any       (w_any)
  );

  assign w_a    = req_a[int'(w_idx)*A_WIDTH +: A_WIDTH];
  assign w_b    = req_b[int'(w_idx)*B_WIDTH +: B_WIDTH];
  assign w_as   = {1'b0, w_a};
  assign w_full = FULL_W'(w_as) * FULL_W'($signed(w_b));

`ifdef DOWNSAMPLE_MUL_SAT_EN
  assign w_p1 = sat_p(w_full);
`else
  assign w_p1 = w_full[P_WIDTH-1:0];
`endif

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_vld_pipe <= '0;
      r_id       <= '0;
      r_p        <= '0;
    end else if (w_adv) begin
      r_vld_pipe[1] <= w_accept;
      r_id[1]       <= w_idx;
      r_p[1]        <= w_p1;
      for (int s = 2; s <= NUM_STAGE; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        r_id[s]       <= r_id[s-1];
        r_p[s]        <= r_p[s-1];
      end
    end
  end

  assign rsp_valid = r_vld_pipe[NUM_STAGE];
  assign rsp_id    = r_id[NUM_STAGE];
  assign rsp_p     = r_p[NUM_STAGE];
endmodule

// File: tb/tb_downsample_mul_arbiter.sv
// Directed bench for downsample_mul_arbiter at default parameters (4 requesters, 2 stages).
module tb_downsample_mul_arbiter;
  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [23:0] req_a;
  logic [39:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [9:0]  rsp_p;

  int checks   = 0;
  int failures = 0;

`ifdef DOWNSAMPLE_MUL_SAT_EN
  localparam int P_OVF = 511;
`else
  localparam int P_OVF = -424;
`endif

  // Hand-computed products for the fairness operand set.
  int exp_p [4] = '{10, -6, -35, -512};

  // Two-deep expectation: stage-1 contents and output contents.
  logic s1v, ov;
  int   s1id, s1p, oid, op;

  downsample_mul_arbiter dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*6 +: 6]   = 6'(a);
    req_b[i*10 +: 10] = 10'(b);
  endtask

  task automatic chk_out(input string tag);
    chk({tag, "_rv"}, {31'd0, rsp_valid}, {31'd0, ov});
    if (ov) begin
      chk({tag, "_id"}, {30'd0, rsp_id}, oid);
      chk({tag, "_p"}, $signed(rsp_p), op);
    end
  endtask

  initial begin
    ap_rst    = 1'b1;
    req_valid = 4'b0010;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    tick; tick; #1;
    chk("rst_ready", {28'd0, req_ready}, 0);
    chk("rst_rv",    {31'd0, rsp_valid}, 0);
    chk("rst_id",    {30'd0, rsp_id}, 0);
    chk("rst_p",     $signed(rsp_p), 0);
    ap_rst    = 1'b0;
    req_valid = '0;
    tick;

    // Only requester 3 valid with pointer at 0; overflowing operands.
    set_op(3, 3, 200);
    req_valid = 4'b1000;
    #1;
    chk("sparse_ready", {28'd0, req_ready}, 4'b1000);
    tick;
    ov = 1'b0; oid = 0; op = 0;
    s1v = 1'b1; s1id = 3; s1p = P_OVF;

    // All four valid: pointer must have wrapped to 0, so order is 0,1,2,3,...
    set_op(0, 1, 10);
    set_op(1, 2, -3);
    set_op(2, 5, -7);
    set_op(3, 63, -512);
    req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("fair_ready", {28'd0, req_ready}, 1 << (c % 4));
      chk_out("fair");
      tick;
      ov = s1v; oid = s1id; op = s1p;
      s1v = 1'b1; s1id = c % 4; s1p = exp_p[c % 4];
    end

    // Backpressure: output holds id 2, stage 1 holds id 3.
    rsp_ready = 1'b0;
    #1;
    chk("bp_ready", {28'd0, req_ready}, 0);
    chk_out("bp");
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("bp_hold_ready", {28'd0, req_ready}, 0);
      chk_out("bp_hold");
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    #1;
    chk_out("bp_release");
    tick;
    chk("drain_rv", {31'd0, rsp_valid}, 1);
    chk("drain_id", {30'd0, rsp_id}, 3);
    chk("drain_p",  $signed(rsp_p), -512);
    tick;
    chk("drain_empty", {31'd0, rsp_valid}, 0);

    // Two results in flight under stall, then reset.
    rsp_ready = 1'b0;
    set_op(0, 1, 10);
    req_valid = 4'b0001;
    #1;
    chk("pre_rst_ready0", {28'd0, req_ready}, 4'b0001);
    tick;
    req_valid = 4'b0010;
    #1;
    chk("pre_rst_ready1", {28'd0, req_ready}, 4'b0010);
    tick;
    req_valid = '0;
    #1;
    chk("stall_rv", {31'd0, rsp_valid}, 1);
    chk("stall_id", {30'd0, rsp_id}, 0);
    chk("stall_p",  $signed(rsp_p), 10);
    ap_rst = 1'b1;
    tick;
    chk("mid_rst_rv", {31'd0, rsp_valid}, 0);
    chk("mid_rst_id", {30'd0, rsp_id}, 0);
    chk("mid_rst_p",  $signed(rsp_p), 0);
    ap_rst    = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("no_stale_rv", {31'd0, rsp_valid}, 0);
    end
    req_valid = 4'hF;
    #1;
    chk("post_rst_ptr", {28'd0, req_ready}, 4'b0001);
    req_valid = '0;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
